// File: rtl/mem_stage_if.sv
// Data-bus interface between the MEM pipeline stage (master) and the memory system (slave).
interface mem_stage_if #(
    parameter int BUS_ADDR_WIDTH = 32
) ();
    logic                      bus_request;
    logic                      bus_write_enable;
    logic [BUS_ADDR_WIDTH-1:0] bus_addr;
    logic [3:0]                bus_select;
    logic [31:0]               bus_write_data;
    logic [31:0]               bus_read_data;
    logic                      bus_ack;

    modport master (
        output bus_request, bus_write_enable, bus_addr, bus_select, bus_write_data,
        input  bus_read_data, bus_ack
    );
    modport slave (
        input  bus_request, bus_write_enable, bus_addr, bus_select, bus_write_data,
        output bus_read_data, bus_ack
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: big-endian loads/stores over a request/ack bus, stalls while a transfer is open.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int MEM_OP_WIDTH   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [5:0]                stall,
    input  logic                      ex_write_enable,
    input  logic [4:0]                ex_write_addr,
    input  logic [31:0]               ex_write_data,
    input  logic                      ex_write_hilo_enable,
    input  logic [31:0]               ex_write_hi_data,
    input  logic [31:0]               ex_write_lo_data,
    input  logic [MEM_OP_WIDTH-1:0]   ex_mem_op,
    input  logic [BUS_ADDR_WIDTH-1:0] ex_mem_addr,
    input  logic [31:0]               ex_mem_store_data,
    output logic                      mem_write_enable,
    output logic [4:0]                mem_write_addr,
    output logic [31:0]               mem_write_data,
    output logic                      mem_write_hilo_enable,
    output logic [31:0]               mem_write_hi_data,
    output logic [31:0]               mem_write_lo_data,
    mem_stage_if.master               bus,
    output logic                      stall_request,
    output logic                      mem_misaligned
);
    localparam logic [MEM_OP_WIDTH-1:0] OP_LB  = MEM_OP_WIDTH'(1);
    localparam logic [MEM_OP_WIDTH-1:0] OP_LBU = MEM_OP_WIDTH'(2);
    localparam logic [MEM_OP_WIDTH-1:0] OP_LH  = MEM_OP_WIDTH'(3);
    localparam logic [MEM_OP_WIDTH-1:0] OP_LHU = MEM_OP_WIDTH'(4);
    localparam logic [MEM_OP_WIDTH-1:0] OP_LW  = MEM_OP_WIDTH'(5);
    localparam logic [MEM_OP_WIDTH-1:0] OP_SB  = MEM_OP_WIDTH'(6);
    localparam logic [MEM_OP_WIDTH-1:0] OP_SH  = MEM_OP_WIDTH'(7);
    localparam logic [MEM_OP_WIDTH-1:0] OP_SW  = MEM_OP_WIDTH'(8);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, next_state;
    logic [31:0] captured_data;
    logic        capture, bus_active;
    logic        is_load, is_store, is_byte, is_half, is_word, sign_ext;
    logic        misaligned, access_legal;
    logic [3:0]  lane_select;
    logic [31:0] store_data, load_data;
    logic        unused_stall;

    assign unused_stall = &{1'b0, stall[5], stall[3:0]};

    // Big-endian extraction: offset 0 is the most significant byte.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] offset,
                                                 input logic byte_op, input logic half_op,
                                                 input logic signed_op);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        case (offset)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = offset[1] ? word[15:0] : word[31:16];
        if (byte_op)      r = signed_op ? 32'(b) : {24'b0, b};
        else if (half_op) r = signed_op ? 32'(h) : {16'b0, h};
        else              r = word;
        return r;
    endfunction

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        sign_ext = 1'b0;
        case (ex_mem_op)
            OP_LB:   begin is_load  = 1'b1; is_byte = 1'b1; sign_ext = 1'b1; end
            OP_LBU:  begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH:   begin is_load  = 1'b1; is_half = 1'b1; sign_ext = 1'b1; end
            OP_LHU:  begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW:   begin is_load  = 1'b1; is_word = 1'b1; end
            OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:   begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (is_half && ex_mem_addr[0]) || (is_word && (ex_mem_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif
    assign access_legal = (is_load || is_store) && !misaligned;

    always_comb begin
        lane_select = 4'b0000;
        store_data  = ex_mem_store_data;
        if (is_byte) begin
            lane_select = 4'b1000 >> ex_mem_addr[1:0];
            store_data  = {4{ex_mem_store_data[7:0]}};
        end else if (is_half) begin
            lane_select = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
            store_data  = {2{ex_mem_store_data[15:0]}};
        end else if (is_word) begin
            lane_select = 4'b1111;
        end
    end

    assign load_data = extract_load(captured_data, ex_mem_addr[1:0], is_byte, is_half, sign_ext);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            captured_data <= '0;
        end else begin
            state <= next_state;
            if (capture) captured_data <= bus.bus_read_data;
        end
    end

    // A same-cycle ack still passes through DONE, so every access costs two cycles.
    always_comb begin
        next_state = state;
        bus_active = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (access_legal) begin
                    bus_active = 1'b1;
                    if (bus.bus_ack) begin
                        capture    = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                bus_active = 1'b1;
                if (bus.bus_ack) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!stall[4]) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_request       = 1'b0;
        bus.bus_write_enable  = 1'b0;
        bus.bus_addr          = '0;
        bus.bus_select        = 4'b0000;
        bus.bus_write_data    = '0;
        stall_request         = 1'b0;
        mem_misaligned        = 1'b0;
        mem_write_enable      = 1'b0;
        mem_write_addr        = '0;
        mem_write_data        = '0;
        mem_write_hilo_enable = 1'b0;
        mem_write_hi_data     = '0;
        mem_write_lo_data     = '0;
        if (!reset) begin
            bus.bus_request       = bus_active;
            stall_request         = bus_active;
            if (bus_active) begin
                bus.bus_write_enable = is_store;
                bus.bus_addr         = {ex_mem_addr[BUS_ADDR_WIDTH-1:2], 2'b00};
                bus.bus_select       = lane_select;
                bus.bus_write_data   = is_store ? store_data : 32'h0;
            end
            mem_misaligned        = misaligned;
            mem_write_addr        = ex_write_addr;
            mem_write_enable      = ex_write_enable;
            mem_write_data        = ex_write_data;
            mem_write_hilo_enable = ex_write_hilo_enable;
            mem_write_hi_data     = ex_write_hi_data;
            mem_write_lo_data     = ex_write_lo_data;
            if (is_load) begin
                mem_write_enable = (state == DONE) && ex_write_enable;
                mem_write_data   = (state == DONE) ? load_data : 32'h0;
            end
            if (misaligned) mem_write_enable = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, wait states, DONE hold, reset in WAIT, alignment.
module tb_mem_stage;
    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                           OP_LHU = 4'd4, OP_LW = 4'd5, OP_SH = 4'd7;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  stall;
    logic        ex_write_enable, ex_write_hilo_enable;
    logic [4:0]  ex_write_addr;
    logic [31:0] ex_write_data, ex_write_hi_data, ex_write_lo_data;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr, ex_mem_store_data;
    logic        mem_write_enable, mem_write_hilo_enable;
    logic [4:0]  mem_write_addr;
    logic [31:0] mem_write_data, mem_write_hi_data, mem_write_lo_data;
    logic        stall_request, mem_misaligned;
    int          checks = 0;
    int          passed = 0;

    always #5 clock = ~clock;

    mem_stage_if #(.BUS_ADDR_WIDTH(32)) bus_if ();

    mem_stage #(.BUS_ADDR_WIDTH(32), .MEM_OP_WIDTH(4)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .stall                 (stall),
        .ex_write_enable       (ex_write_enable),
        .ex_write_addr         (ex_write_addr),
        .ex_write_data         (ex_write_data),
        .ex_write_hilo_enable  (ex_write_hilo_enable),
        .ex_write_hi_data      (ex_write_hi_data),
        .ex_write_lo_data      (ex_write_lo_data),
        .ex_mem_op             (ex_mem_op),
        .ex_mem_addr           (ex_mem_addr),
        .ex_mem_store_data     (ex_mem_store_data),
        .mem_write_enable      (mem_write_enable),
        .mem_write_addr        (mem_write_addr),
        .mem_write_data        (mem_write_data),
        .mem_write_hilo_enable (mem_write_hilo_enable),
        .mem_write_hi_data     (mem_write_hi_data),
        .mem_write_lo_data     (mem_write_lo_data),
        .bus                   (bus_if.master),
        .stall_request         (stall_request),
        .mem_misaligned        (mem_misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts in IDLE, acks in the request cycle, checks DONE, then returns to IDLE.
    task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_data,
                           input logic [3:0] exp_sel);
        ex_mem_op             = op;
        ex_mem_addr           = addr;
        ex_write_enable       = 1'b1;
        bus_if.bus_read_data  = rdata;
        bus_if.bus_ack        = 1'b1;
        #1;
        check({tag, "_req"},   {31'b0, bus_if.bus_request}, 32'd1);
        check({tag, "_stall"}, {31'b0, stall_request}, 32'd1);
        check({tag, "_sel"},   {28'b0, bus_if.bus_select}, {28'b0, exp_sel});
        check({tag, "_addr"},  bus_if.bus_addr, {addr[31:2], 2'b00});
        check({tag, "_we_busy"}, {31'b0, mem_write_enable}, 32'd0);
        tick();
        bus_if.bus_ack       = 1'b0;
        bus_if.bus_read_data = 32'h0;
        #1;
        check({tag, "_done_stall"}, {31'b0, stall_request}, 32'd0);
        check({tag, "_done_req"},   {31'b0, bus_if.bus_request}, 32'd0);
        check({tag, "_we"},   {31'b0, mem_write_enable}, 32'd1);
        check({tag, "_data"}, mem_write_data, exp_data);
        ex_mem_op = OP_NONE;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; stall = 6'b0;
        ex_write_enable = 1'b1; ex_write_addr = 5'd9; ex_write_data = 32'h55;
        ex_write_hilo_enable = 1'b1; ex_write_hi_data = 32'h77; ex_write_lo_data = 32'h88;
        ex_mem_op = OP_LW; ex_mem_addr = 32'h100; ex_mem_store_data = 32'h0;
        bus_if.bus_read_data = 32'h0; bus_if.bus_ack = 1'b0;
        tick(); tick();
        check("rst_req",   {31'b0, bus_if.bus_request}, 32'd0);
        check("rst_stall", {31'b0, stall_request}, 32'd0);
        check("rst_we",    {31'b0, mem_write_enable}, 32'd0);
        check("rst_data",  mem_write_data, 32'h0);
        check("rst_hi",    mem_write_hi_data, 32'h0);

        reset = 1'b0; ex_mem_op = OP_NONE;
        ex_write_addr = 5'd5; ex_write_data = 32'h1234;
        ex_write_hi_data = 32'hAAAA; ex_write_lo_data = 32'hBBBB;
        tick();
        check("none_we",    {31'b0, mem_write_enable}, 32'd1);
        check("none_addr",  {27'b0, mem_write_addr}, 32'd5);
        check("none_data",  mem_write_data, 32'h1234);
        check("none_hilo",  {31'b0, mem_write_hilo_enable}, 32'd1);
        check("none_hi",    mem_write_hi_data, 32'hAAAA);
        check("none_lo",    mem_write_lo_data, 32'hBBBB);
        check("none_stall", {31'b0, stall_request}, 32'd0);
        check("none_bus",   bus_if.bus_addr, 32'h0);

        do_load("lw",   OP_LW,  32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
        do_load("lb",   OP_LB,  32'h101, 32'h12845678, 32'hFFFFFF84, 4'b0100);
        do_load("lbu",  OP_LBU, 32'h101, 32'h12845678, 32'h00000084, 4'b0100);
        do_load("lb0",  OP_LB,  32'h100, 32'h7F000000, 32'h0000007F, 4'b1000);
        do_load("lh",   OP_LH,  32'h102, 32'h00009ABC, 32'hFFFF9ABC, 4'b0011);
        do_load("lhu",  OP_LHU, 32'h100, 32'h80010000, 32'h00008001, 4'b1100);

        ex_mem_op = OP_SH; ex_mem_addr = 32'h102; ex_mem_store_data = 32'h0000BEEF;
        ex_write_enable = 1'b0; bus_if.bus_read_data = 32'h13572468;
        #1;
        check("sh_req",   {31'b0, bus_if.bus_request}, 32'd1);
        check("sh_wen",   {31'b0, bus_if.bus_write_enable}, 32'd1);
        check("sh_sel",   {28'b0, bus_if.bus_select}, 32'h3);
        check("sh_wdata", bus_if.bus_write_data, 32'hBEEFBEEF);
        check("sh_addr",  bus_if.bus_addr, 32'h100);
        bus_if.bus_ack = 1'b1;
        tick();
        bus_if.bus_ack = 1'b0;
        #1;
        check("sh_done_stall", {31'b0, stall_request}, 32'd0);
        check("sh_done_wdata", bus_if.bus_write_data, 32'h0);
        check("sh_done_we",    {31'b0, mem_write_enable}, 32'd0);
        ex_mem_op = OP_NONE;
        tick();

        ex_mem_op = OP_LW; ex_mem_addr = 32'h200; ex_write_enable = 1'b1;
        bus_if.bus_read_data = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus_if.bus_ack = 1'b1;
            #1;
            check("wait_stall", {31'b0, stall_request}, 32'd1);
            check("wait_addr",  bus_if.bus_addr, 32'h200);
            check("wait_sel",   {28'b0, bus_if.bus_select}, 32'hF);
            check("wait_we",    {31'b0, mem_write_enable}, 32'd0);
            tick();
        end
        bus_if.bus_ack = 1'b0; bus_if.bus_read_data = 32'h0; stall = 6'b010000;
        #1;
        check("wait_done_stall", {31'b0, stall_request}, 32'd0);
        check("wait_done_data",  mem_write_data, 32'hCAFEF00D);
        tick(); tick();
        check("hold_req",  {31'b0, bus_if.bus_request}, 32'd0);
        check("hold_we",   {31'b0, mem_write_enable}, 32'd1);
        check("hold_data", mem_write_data, 32'hCAFEF00D);
        stall = 6'b0;
        tick();
        check("release_req", {31'b0, bus_if.bus_request}, 32'd1);
        tick();
        check("rw_wait_req", {31'b0, bus_if.bus_request}, 32'd1);
        reset = 1'b1;
        #1;
        check("rw_rst_req",   {31'b0, bus_if.bus_request}, 32'd0);
        check("rw_rst_stall", {31'b0, stall_request}, 32'd0);
        tick();
        reset = 1'b0; ex_mem_op = OP_NONE; ex_write_enable = 1'b0;
        bus_if.bus_ack = 1'b1; bus_if.bus_read_data = 32'hFFFFFFFF;
        #1;
        check("rw_after_req",   {31'b0, bus_if.bus_request}, 32'd0);
        check("rw_after_stall", {31'b0, stall_request}, 32'd0);
        tick();
        check("rw_stray_we",  {31'b0, mem_write_enable}, 32'd0);
        check("rw_stray_req", {31'b0, bus_if.bus_request}, 32'd0);
        bus_if.bus_ack = 1'b0;

        ex_mem_op = OP_LW; ex_mem_addr = 32'h102; ex_write_enable = 1'b1;
        bus_if.bus_read_data = 32'h11223344;
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_flag",  {31'b0, mem_misaligned}, 32'd1);
        check("mis_req",   {31'b0, bus_if.bus_request}, 32'd0);
        check("mis_stall", {31'b0, stall_request}, 32'd0);
        check("mis_we",    {31'b0, mem_write_enable}, 32'd0);
        ex_mem_op = OP_NONE;
        tick();
`else
        check("mis_flag", {31'b0, mem_misaligned}, 32'd0);
        check("mis_req",  {31'b0, bus_if.bus_request}, 32'd1);
        check("mis_addr", bus_if.bus_addr, 32'h100);
        bus_if.bus_ack = 1'b1;
        tick();
        bus_if.bus_ack = 1'b0;
        #1;
        check("mis_data", mem_write_data, 32'h11223344);
        ex_mem_op = OP_NONE;
        tick();
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
